// File: rtl/bus_ram_dp.sv
// bus_ram_dp: dual-port byte-masked RAM with valid/ready requests, fixed-latency responses and optional clear sweep
module bus_ram_dp #(
  parameter int DEPTH = 1024,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int LATENCY = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  input  logic [DATA_W/8-1:0] a_wmask,
  output logic                a_rvalid,
  output logic [DATA_W-1:0]   a_rdata,
  output logic                a_err,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  input  logic [DATA_W/8-1:0] b_wmask,
  output logic                b_rvalid,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                b_err
);
  localparam int BW = DATA_W / 8;
  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state;
  logic [AW-1:0] cnt;
  logic rdy;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] dq [2][LATENCY];
  logic [1:0] acc, inr;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][DATA_W-1:0] wdata, last, dout;
  logic [1:0][BW-1:0] wmask;
  logic [1:0][LATENCY-1:0] v, e;
  assign acc = {b_valid, a_valid} & {2{rdy}};
  assign addr = {b_addr, a_addr};
  assign wdata = {b_wdata, a_wdata};
  assign wmask = {b_wmask, a_wmask};
  assign inr = {{1'b0, b_addr} < LIM, {1'b0, a_addr} < LIM};
  assign a_ready = rdy;
  assign b_ready = rdy;
  assign a_rvalid = v[0][LATENCY-1];
  assign b_rvalid = v[1][LATENCY-1];
  assign a_err = v[0][LATENCY-1] & e[0][LATENCY-1];
  assign b_err = v[1][LATENCY-1] & e[1][LATENCY-1];
  assign a_rdata = v[0][LATENCY-1] ? dout[0] : last[0];
  assign b_rdata = v[1][LATENCY-1] ? dout[1] : last[1];
  // out-of-range responses read as zero at the final stage
  always_comb
    for (int p = 0; p < 2; p++) dout[p] = e[p][LATENCY-1] ? '0 : dq[p][LATENCY-1];
  // clear sweep then run; ready registered so it is low through reset and the sweep
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= CLEAR_ON_RESET != 0 ? CLEAR : RUN;
      cnt <= '0;
      rdy <= 1'b0;
    end else begin
      if (state == CLEAR) cnt <= cnt + 1'b1;
      if (state == CLEAR && cnt == LAST) state <= RUN;
      rdy <= state == RUN || cnt == LAST;
    end
  // unreset array: B lanes written first so A's later assignment wins on collision; reads are read-first
  always_ff @(posedge clock) begin
    if (state == CLEAR) mem[cnt] <= INIT_VALUE;
    for (int p = 1; p >= 0; p--)
      for (int i = 0; i < BW; i++)
        if (acc[p] && inr[p] && wmask[p][i]) mem[addr[p][AW-1:0]][i*8 +: 8] <= wdata[p][i*8 +: 8];
    for (int p = 0; p < 2; p++) begin
      if (acc[p]) dq[p][0] <= mem[addr[p][AW-1:0]];
      for (int k = 1; k < LATENCY; k++) dq[p][k] <= dq[p][k-1];
    end
  end
  // response valid/err pipeline, flushed by reset; last keeps rdata stable between responses
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      v <= '0;
      e <= '0;
      last <= '0;
    end else
      for (int p = 0; p < 2; p++) begin
        v[p][0] <= acc[p];
        e[p][0] <= !inr[p];
        for (int k = 1; k < LATENCY; k++) begin
          v[p][k] <= v[p][k-1];
          e[p][k] <= e[p][k-1];
        end
        if (v[p][LATENCY-1]) last[p] <= dout[p];
      end
endmodule

// File: tb/tb_bus_ram_dp.sv
// tb_bus_ram_dp: scoreboard bench for two bus_ram_dp configurations
module tb_bus_ram_dp;
  typedef struct {int cyc; logic [31:0] data; bit err; bit known;} exp_t;
  logic clock = 0, reset = 1;
  logic valid [2][2], ready [2][2], rvalid [2][2], err [2][2];
  logic [29:0] addr [2][2];
  logic [31:0] wdata [2][2], rdata [2][2];
  logic [3:0] wmask [2][2];
  logic [31:0] mdl [2][1024];
  bit known [2][1024];
  exp_t q [4][$];
  int dep [2] = '{16, 1024};
  int lat [2] = '{3, 1};
  int cyc = 0, n_chk = 0, n_fail = 0;
  always #5 clock = ~clock;
  bus_ram_dp #(.DEPTH(16), .ADDR_W(30), .DATA_W(32), .LATENCY(3), .CLEAR_ON_RESET(1), .INIT_VALUE(32'hA5A5A5A5)) u0 (
    .clock(clock), .reset(reset),
    .a_valid(valid[0][0]), .a_ready(ready[0][0]), .a_addr(addr[0][0]), .a_wdata(wdata[0][0]), .a_wmask(wmask[0][0]),
    .a_rvalid(rvalid[0][0]), .a_rdata(rdata[0][0]), .a_err(err[0][0]),
    .b_valid(valid[0][1]), .b_ready(ready[0][1]), .b_addr(addr[0][1]), .b_wdata(wdata[0][1]), .b_wmask(wmask[0][1]),
    .b_rvalid(rvalid[0][1]), .b_rdata(rdata[0][1]), .b_err(err[0][1]));
  bus_ram_dp #(.DEPTH(1024), .ADDR_W(30), .DATA_W(32), .LATENCY(1), .CLEAR_ON_RESET(0), .INIT_VALUE(32'h0)) u1 (
    .clock(clock), .reset(reset),
    .a_valid(valid[1][0]), .a_ready(ready[1][0]), .a_addr(addr[1][0]), .a_wdata(wdata[1][0]), .a_wmask(wmask[1][0]),
    .a_rvalid(rvalid[1][0]), .a_rdata(rdata[1][0]), .a_err(err[1][0]),
    .b_valid(valid[1][1]), .b_ready(ready[1][1]), .b_addr(addr[1][1]), .b_wdata(wdata[1][1]), .b_wmask(wmask[1][1]),
    .b_rvalid(rvalid[1][1]), .b_rdata(rdata[1][1]), .b_err(err[1][1]));
  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  task idle();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        valid[d][p] = 0;
        addr[d][p] = '0;
        wdata[d][p] = '0;
        wmask[d][p] = '0;
      end
  endtask
  task drive(input int d, input int p, input logic [29:0] a, input logic [31:0] w, input logic [3:0] m);
    valid[d][p] = 1;
    addr[d][p] = a;
    wdata[d][p] = w;
    wmask[d][p] = m;
  endtask
  task monitor();
    exp_t e;
    bit due;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        due = q[d*2+p].size() > 0 && q[d*2+p][0].cyc <= cyc;
        check($sformatf("rvalid_d%0d_p%0d", d, p), rvalid[d][p], due);
        if (!rvalid[d][p]) check($sformatf("err_idle_d%0d_p%0d", d, p), err[d][p], 0);
        if (due) begin
          e = q[d*2+p].pop_front();
          if (rvalid[d][p]) begin
            check($sformatf("err_d%0d_p%0d", d, p), err[d][p], e.err);
            if (e.known) check($sformatf("rdata_d%0d_p%0d", d, p), rdata[d][p], e.data);
          end
        end
      end
  endtask
  task step();
    exp_t e;
    bit acc [2][2];
    bit inr [2][2];
    logic [9:0] a;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        acc[d][p] = valid[d][p] && ready[d][p] && !reset;
        inr[d][p] = 32'(addr[d][p]) < 32'(dep[d]);
        a = addr[d][p][9:0];
        if (acc[d][p]) begin
          e.cyc = cyc + lat[d];
          e.err = !inr[d][p];
          e.data = inr[d][p] ? mdl[d][a] : 32'h0;
          e.known = inr[d][p] ? known[d][a] : 1'b1;
          q[d*2+p].push_back(e);
        end
      end
    for (int d = 0; d < 2; d++)
      for (int p = 1; p >= 0; p--)
        if (acc[d][p] && inr[d][p]) begin
          a = addr[d][p][9:0];
          for (int b = 0; b < 4; b++)
            if (wmask[d][p][b]) mdl[d][a][b*8 +: 8] = wdata[d][p][b*8 +: 8];
          if (wmask[d][p] == 4'hF) known[d][a] = 1;
        end
    @(posedge clock);
    cyc++;
    @(negedge clock);
    monitor();
  endtask
  task wait_sweep();
    int n;
    n = 0;
    while (ready[0][0] !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("sweep_cycles", n, 16);
  endtask
  task sweep_model();
    for (int i = 0; i < 16; i++) begin
      mdl[0][i] = 32'hA5A5A5A5;
      known[0][i] = 1;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    idle();
    for (int i = 0; i < 1024; i++) begin
      known[1][i] = 0;
      mdl[1][i] = '0;
      known[0][i] = 0;
      mdl[0][i] = '0;
    end
    sweep_model();
    repeat (2) @(negedge clock);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        check("rst_ready", ready[d][p], 0);
        check("rst_rvalid", rvalid[d][p], 0);
        check("rst_err", err[d][p], 0);
        check("rst_rdata", rdata[d][p], 0);
      end
    drive(0, 0, 7, 0, 0);
    reset = 0;
    wait_sweep();
    step();
    idle();
    drive(0, 0, 3, 32'h11223344, 4'hF); drive(1, 1, 3, 32'h11223344, 4'hF); step();
    drive(0, 0, 3, 32'hAABBCCDD, 4'b0101); drive(1, 1, 3, 32'hAABBCCDD, 4'b0101); step();
    drive(0, 0, 3, 0, 0); drive(1, 1, 3, 0, 0); step();
    idle();
    for (int d = 0; d < 2; d++) drive(d, 0, 5, 32'h0, 4'hF);
    step();
    for (int d = 0; d < 2; d++) begin
      drive(d, 0, 5, 32'hFFFF0000, 4'b1100);
      drive(d, 1, 5, 32'h0000FFFF, 4'b1111);
    end
    step();
    for (int d = 0; d < 2; d++) begin
      drive(d, 0, 5, 32'h12345678, 4'b1111);
      drive(d, 1, 5, 32'h9ABCDEF0, 4'b0011);
    end
    step();
    for (int d = 0; d < 2; d++) begin
      drive(d, 0, 5, 0, 0);
      drive(d, 1, 5, 0, 0);
    end
    step();
    idle();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 30'(i), 0, 0);
      drive(1, 1, 30'(i), 0, 0);
      step();
    end
    idle();
    drive(1, 0, 0, 32'h0BADF00D, 4'hF); step();
    drive(1, 0, 1024, 32'hDEADBEEF, 4'hF); drive(0, 0, 16, 32'hDEADBEEF, 4'hF); step();
    drive(1, 0, 30'h2000_0000, 32'hCAFEBABE, 4'hF); drive(0, 0, 30'h2000_0000, 32'hCAFEBABE, 4'hF); step();
    drive(1, 0, 1024, 0, 0); drive(0, 0, 16, 0, 0); step();
    drive(1, 0, 0, 0, 0); drive(0, 0, 0, 0, 0); step();
    idle();
    repeat (5) step();
    drive(0, 0, 3, 0, 0); step();
    drive(0, 0, 5, 0, 0); step();
    reset = 1;
    for (int i = 0; i < 4; i++) q[i].delete();
    sweep_model();
    #1;
    step();
    reset = 0;
    wait_sweep();
    step();
    idle();
    drive(1, 0, 3, 0, 0); drive(1, 1, 5, 0, 0); drive(0, 1, 3, 0, 0); step();
    idle();
    repeat (6) step();
    for (int i = 0; i < 4; i++) check($sformatf("queue_empty_%0d", i), q[i].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
